enet_gmii_tx_framer: RTL and testbench

MAC transmit framer that drives the GMII transmit side (gmii_tx_en/gmii_tx_er/gmii_txd) feeding the RGMII/GMII converter.
Accepts a byte stream per frame (destination MAC through payload, no FCS) over a valid/ready/last handshake.
Emits preamble, SFD, data, optional zero padding, CRC-32 FCS, then enforces the inter-frame gap.
Runs entirely in the GMII transmit clock domain.

---
 rtl/enet_pkg.sv | 20 ++
 rtl/enet_crc32_d8.sv | 17 +
 rtl/enet_gmii_tx_framer.sv | 164 ++++++++++++++++
 tb/tb_enet_gmii_tx_framer.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/enet_pkg.sv
// Shared Ethernet constants and the transmit framer state encoding.
package enet_pkg;

    localparam logic [7:0]  ENET_PREAMBLE     = 8'h55;
    localparam logic [7:0]  ENET_SFD          = 8'hD5;
    localparam logic [31:0] ENET_CRC_INIT     = 32'hFFFF_FFFF;
    localparam logic [31:0] ENET_CRC_POLY     = 32'hEDB8_8320;
    localparam int          ENET_PREAMBLE_LEN = 7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_SFD,
        ST_DATA,
        ST_PAD,
        ST_FCS,
        ST_IFG
    } tx_state_e;

endpackage

// File: rtl/enet_crc32_d8.sv
// Combinational CRC-32 (reflected IEEE polynomial) advanced by one byte, LSB first.
module enet_crc32_d8
    import enet_pkg::*;
(
    input  logic [31:0] crc,
    input  logic [7:0]  data,
    output logic [31:0] crc_next
);

    always_comb begin
        crc_next = crc;
        for (int i = 0; i < 8; i++) begin
            crc_next = (crc_next >> 1) ^ ((crc_next[0] ^ data[i]) ? ENET_CRC_POLY : 32'h0);
        end
    end

endmodule

// File: rtl/enet_gmii_tx_framer.sv
// GMII transmit framer: preamble, SFD, data, optional pad, FCS, inter-frame gap.
// Define ENET_GMII_TX_PAD_EN to zero-pad short frames up to MIN_FRAME_BYTES.
module enet_gmii_tx_framer
    import enet_pkg::*;
#(
    parameter int IFG_BYTES       = 12,
    parameter int MIN_FRAME_BYTES = 60
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    input  logic       s_last,
    output logic       s_ready,
    output logic       gmii_tx_en,
    output logic       gmii_tx_er,
    output logic [7:0] gmii_txd,
    output logic       frame_done,
    output logic       underrun
);

`ifdef ENET_GMII_TX_PAD_EN
    localparam bit PAD_EN = 1'b1;
`else
    localparam bit PAD_EN = 1'b0;
`endif

    // IDLE emits the first preamble byte, so PREAMBLE only covers the rest.
    localparam logic [5:0]  PRE_LAST = 6'(ENET_PREAMBLE_LEN - 2);
    localparam logic [5:0]  IFG_LAST = 6'(IFG_BYTES - 1);
    localparam logic [10:0] MIN_LEN  = 11'(MIN_FRAME_BYTES);

    tx_state_e   state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [10:0] byte_cnt_q, byte_cnt_d, byte_cnt_inc;
    logic [31:0] crc_q, crc_d, crc_next, fcs_word;
    logic [7:0]  crc_byte;
    logic        tx_en_d, tx_er_d, frame_done_d, underrun_d;
    logic [7:0]  txd_d;

    enet_crc32_d8 u_crc (
        .crc      (crc_q),
        .data     (crc_byte),
        .crc_next (crc_next)
    );

    assign s_ready      = (state_q == ST_DATA);
    assign byte_cnt_inc = (byte_cnt_q == 11'h7FF) ? byte_cnt_q : byte_cnt_q + 11'd1;
    assign fcs_word     = ~crc_q;

    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        byte_cnt_d   = byte_cnt_q;
        crc_d        = crc_q;
        crc_byte     = s_data;
        tx_en_d      = 1'b0;
        tx_er_d      = 1'b0;
        txd_d        = 8'h00;
        frame_done_d = 1'b0;
        underrun_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (s_valid) begin
                    tx_en_d = 1'b1;
                    txd_d   = ENET_PREAMBLE;
                    cnt_d   = '0;
                    state_d = ST_PREAMBLE;
                end
            end
            ST_PREAMBLE: begin
                tx_en_d = 1'b1;
                txd_d   = ENET_PREAMBLE;
                if (cnt_q == PRE_LAST) begin
                    state_d = ST_SFD;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            ST_SFD: begin
                tx_en_d    = 1'b1;
                txd_d      = ENET_SFD;
                byte_cnt_d = '0;
                crc_d      = ENET_CRC_INIT;
                state_d    = ST_DATA;
            end
            ST_DATA: begin
                tx_en_d = 1'b1;
                if (s_valid) begin
                    txd_d      = s_data;
                    crc_d      = crc_next;
                    byte_cnt_d = byte_cnt_inc;
                    if (s_last) begin
                        cnt_d   = '0;
                        state_d = (PAD_EN && (byte_cnt_inc < MIN_LEN)) ? ST_PAD : ST_FCS;
                    end
                end else begin
                    // Upstream starved us mid-frame: poison the frame and skip pad/FCS.
                    tx_er_d    = 1'b1;
                    underrun_d = 1'b1;
                    cnt_d      = '0;
                    state_d    = ST_IFG;
                end
            end
            ST_PAD: begin
                tx_en_d    = 1'b1;
                crc_byte   = 8'h00;
                crc_d      = crc_next;
                byte_cnt_d = byte_cnt_inc;
                if (byte_cnt_inc >= MIN_LEN) begin
                    cnt_d   = '0;
                    state_d = ST_FCS;
                end
            end
            ST_FCS: begin
                tx_en_d = 1'b1;
                txd_d   = fcs_word[{cnt_q[1:0], 3'b000} +: 8];
                if (cnt_q[1:0] == 2'd3) begin
                    frame_done_d = 1'b1;
                    cnt_d        = '0;
                    state_d      = ST_IFG;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            ST_IFG: begin
                if (cnt_q == IFG_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            byte_cnt_q <= '0;
            crc_q      <= ENET_CRC_INIT;
            gmii_tx_en <= 1'b0;
            gmii_tx_er <= 1'b0;
            gmii_txd   <= 8'h00;
            frame_done <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            byte_cnt_q <= byte_cnt_d;
            crc_q      <= crc_d;
            gmii_tx_en <= tx_en_d;
            gmii_tx_er <= tx_er_d;
            gmii_txd   <= txd_d;
            frame_done <= frame_done_d;
            underrun   <= underrun_d;
        end
    end

endmodule

// File: tb/tb_enet_gmii_tx_framer.sv
// Scoreboard bench for enet_gmii_tx_framer: driver queues expected wire bytes, negedge monitor compares.
module tb_enet_gmii_tx_framer;

    localparam int IFG     = 12;
    localparam int MIN_LEN = 60;

    typedef logic [7:0] bytes_t[$];
    typedef struct packed {
        logic       er;
        logic [7:0] txd;
        logic       done;
        logic       urun;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] s_data = 8'h00;
    logic       s_valid = 1'b0;
    logic       s_last = 1'b0;
    logic       s_ready, gmii_tx_en, gmii_tx_er, frame_done, underrun;
    logic [7:0] gmii_txd;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    enet_gmii_tx_framer #(.IFG_BYTES(IFG), .MIN_FRAME_BYTES(MIN_LEN)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_last     (s_last),
        .s_ready    (s_ready),
        .gmii_tx_en (gmii_tx_en),
        .gmii_tx_er (gmii_tx_er),
        .gmii_txd   (gmii_txd),
        .frame_done (frame_done),
        .underrun   (underrun)
    );

    always #4 clk = ~clk;

    function automatic logic [31:0] crc_model(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int b = 0; b < 8; b++) r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic push(input logic er, input logic [7:0] txd, input logic done, input logic urun);
        exp_t e;
        e.er = er; e.txd = txd; e.done = done; e.urun = urun;
        exp_q.push_back(e);
    endtask

    // Called at a negedge; returns at the negedge after the byte has transferred.
    task automatic send(input logic [7:0] d, input logic l);
        int guard = 0;
        s_data = d; s_last = l; s_valid = 1'b1;
        while (!s_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!s_ready) check("s_ready_timeout", 32'(s_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send_frame(input bytes_t data, input int drop_after, input int fcs_keep,
                              input bit use_fixed, input logic [31:0] fixed_fcs);
        logic [31:0] crc = 32'hFFFF_FFFF;
        logic [31:0] fcs;
        int n = data.size();
        for (int i = 0; i < 7; i++) push(1'b0, 8'h55, 1'b0, 1'b0);
        push(1'b0, 8'hD5, 1'b0, 1'b0);
        for (int i = 0; i < n; i++) begin
            if (i == drop_after) begin
                push(1'b1, 8'h00, 1'b0, 1'b1);
                s_valid = 1'b0; s_last = 1'b0;
                @(posedge clk);
                @(negedge clk);
                return;
            end
            push(1'b0, data[i], 1'b0, 1'b0);
            crc = crc_model(crc, data[i]);
            send(data[i], i == n - 1);
        end
`ifdef ENET_GMII_TX_PAD_EN
        for (int i = n; i < MIN_LEN; i++) begin
            push(1'b0, 8'h00, 1'b0, 1'b0);
            crc = crc_model(crc, 8'h00);
        end
`endif
        fcs = use_fixed ? fixed_fcs : ~crc;
        for (int k = 0; k < fcs_keep; k++) push(1'b0, fcs[8*k +: 8], k == 3, 1'b0);
    endtask

    // Monitor: every tx_en cycle is matched against the scoreboard; idle cycles must be quiet.
    initial begin : monitor
        exp_t e;
        int   idle_run = 0;
        bit   seen_frame = 1'b0;
        bit   prev_en = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                seen_frame = 1'b0;
                idle_run   = 0;
                prev_en    = 1'b0;
            end else if (gmii_tx_en) begin
                if (!prev_en && seen_frame) check("ifg_length", 32'(idle_run), 32'(IFG));
                if (exp_q.size() == 0) begin
                    check("unexpected_tx_byte", {23'h0, gmii_tx_er, gmii_txd}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("wire_byte", {20'h0, gmii_tx_er, gmii_txd, frame_done, underrun},
                          {20'h0, e.er, e.txd, e.done, e.urun});
                end
                seen_frame = 1'b1;
                idle_run   = 0;
                prev_en    = 1'b1;
            end else begin
                check("idle_quiet", {21'h0, gmii_tx_er, gmii_txd, frame_done, underrun}, 32'h0);
                idle_run++;
                prev_en = 1'b0;
            end
        end
    end

    initial begin : driver
        bytes_t f;
        int     guard;

        // Reset state, with s_valid high to show it is ignored under reset.
        s_valid = 1'b1;
        #3;
        check("reset_outputs", {26'h0, s_ready, gmii_tx_en, gmii_tx_er, frame_done, underrun, |gmii_txd}, 32'h0);
        s_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_not_ready", 32'(s_ready), 32'd0);

        // "123456789": known-answer FCS 26 39 F4 CB when unpadded.
        f = {};
        for (int i = 0; i < 9; i++) f.push_back(8'h31 + 8'(i));
`ifdef ENET_GMII_TX_PAD_EN
        send_frame(f, -1, 4, 1'b0, 32'h0);
`else
        send_frame(f, -1, 4, 1'b1, 32'hCBF4_3926);
`endif

        // Two back-to-back 60-byte frames, s_valid held high throughout.
        for (int fr = 0; fr < 2; fr++) begin
            f = {};
            for (int i = 0; i < 60; i++) f.push_back(8'(i * 7 + fr * 91 + 3));
            send_frame(f, -1, 4, 1'b0, 32'h0);
        end

        // Underrun after the 10th byte; the remaining 10 bytes follow as their own frame.
        f = {};
        for (int i = 0; i < 20; i++) f.push_back(8'hA0 + 8'(i));
        send_frame(f, 10, 4, 1'b0, 32'h0);
        f = {};
        for (int i = 10; i < 20; i++) f.push_back(8'hA0 + 8'(i));
        send_frame(f, -1, 4, 1'b0, 32'h0);

`ifdef ENET_GMII_TX_PAD_EN
        f = {};
        f.push_back(8'hAB);
        send_frame(f, -1, 4, 1'b0, 32'h0);
        f = {};
        for (int i = 0; i < 64; i++) f.push_back(8'(255 - i));
        send_frame(f, -1, 4, 1'b0, 32'h0);
`endif

        f = {8'hDE, 8'hAD, 8'hBE};
        send_frame(f, -1, 4, 1'b0, 32'h0);

        // Reset during the second FCS byte of a 60-byte frame.
        f = {};
        for (int i = 0; i < 60; i++) f.push_back(8'(i ^ 8'h5A));
        send_frame(f, -1, 1, 1'b0, 32'h0);
        s_valid = 1'b0; s_last = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_outputs", {26'h0, s_ready, gmii_tx_en, gmii_tx_er, frame_done, underrun, |gmii_txd}, 32'h0);
        check("scoreboard_drained_at_reset", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Clean frame after reset proves the CRC is re-initialised.
        f = {};
        for (int i = 0; i < 9; i++) f.push_back(8'h31 + 8'(i));
`ifdef ENET_GMII_TX_PAD_EN
        send_frame(f, -1, 4, 1'b0, 32'h0);
`else
        send_frame(f, -1, 4, 1'b1, 32'hCBF4_3926);
`endif
        s_valid = 1'b0; s_last = 1'b0;

        guard = 0;
        while (exp_q.size() != 0 && guard < 400) begin
            @(negedge clk);
            guard++;
        end
        repeat (IFG + 4) @(negedge clk);
        check("scoreboard_drained_at_end", 32'(exp_q.size()), 32'd0);
        check("final_idle_not_ready", 32'(s_ready), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
